// File: rtl/best_arr_sender_pkg.sv
// Shared parameters and types for the best-result drain stage.
// Geometry, address width and FSM encodings live here.
package best_arr_sender_pkg;

   localparam int DATA_WIDTH = 11;
   localparam int ROW_SIZE   = 32;
   localparam int COL_SIZE   = 16;
   localparam int BLOCKING   = 4;
   localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
   localparam int ADDR_WIDTH = $clog2(NUM_QUERYS);
   localparam int X_NUM      = ROW_SIZE / (2 * BLOCKING);

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int XI_W = cw(BLOCKING);
   localparam int Y_W  = cw(COL_SIZE);
   localparam int X_W  = cw(X_NUM);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      PUSH,
      DONE
   } state_e;

   typedef enum logic {
      P_IDX,
      P_DIST
   } pass_e;

endpackage

// File: rtl/best_arr_sender_if.sv
// Result-buffer read port and output-FIFO write port.
// The sender drives the master side.
interface best_arr_sender_if;
   import best_arr_sender_pkg::*;

   logic                    mem_rd_en;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   best_idx_rdata;
   logic [2*DATA_WIDTH-1:0] best_dist_rdata;
   logic                    out_fifo_wenq;
   logic [DATA_WIDTH-1:0]   out_fifo_wdata;
   logic                    out_fifo_wfull_n;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  best_idx_rdata,
      input  best_dist_rdata,
      output out_fifo_wenq,
      output out_fifo_wdata,
      input  out_fifo_wfull_n
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output best_idx_rdata,
      output best_dist_rdata,
      input  out_fifo_wenq,
      input  out_fifo_wdata,
      output out_fifo_wfull_n
   );

endinterface

// File: rtl/best_arr_sender_blocked_raster_counter.sv
// Nested px/x/y/xi counters producing the blocked raster address.
// o_last flags the final position so the caller can end a pass.
module blocked_raster_counter
   import best_arr_sender_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_adv,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);

   logic            r_px;
   logic [X_W-1:0]  r_x;
   logic [Y_W-1:0]  r_y;
   logic [XI_W-1:0] r_xi;

   logic w_xi_wrap;
   logic w_y_wrap;
   logic w_x_wrap;

   assign w_xi_wrap = (r_xi == XI_W'(BLOCKING - 1));
   assign w_y_wrap  = (r_y == Y_W'(COL_SIZE - 1));
   assign w_x_wrap  = (r_x == X_W'(X_NUM - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_px <= 1'b0;
         r_x  <= '0;
         r_y  <= '0;
         r_xi <= '0;
      end else if (i_clr) begin
         r_px <= 1'b0;
         r_x  <= '0;
         r_y  <= '0;
         r_xi <= '0;
      end else if (i_adv) begin
         r_xi <= w_xi_wrap ? '0 : r_xi + 1'b1;
         if (w_xi_wrap) begin
            r_y <= w_y_wrap ? '0 : r_y + 1'b1;
            if (w_y_wrap) begin
               r_x <= w_x_wrap ? '0 : r_x + 1'b1;
               if (w_x_wrap)
                  r_px <= ~r_px;
            end
         end
      end
   end

   assign o_last = r_px & w_x_wrap & w_y_wrap & w_xi_wrap;

   assign o_addr =
      ADDR_WIDTH'(r_px) * ADDR_WIDTH'(ROW_SIZE / 2) +
      ADDR_WIDTH'(r_y)  * ADDR_WIDTH'(ROW_SIZE) +
      ADDR_WIDTH'(r_x)  * ADDR_WIDTH'(BLOCKING) +
      ADDR_WIDTH'(r_xi);

endmodule

// File: rtl/best_arr_sender.sv
// Drains best indices, then best distances (two words each),
// from the result buffers into the output FIFO under backpressure.
module best_arr_sender
   import best_arr_sender_pkg::*;
(
   input  logic                      io_clk,
   input  logic                      io_rst_n,
   input  logic                      send_best_arr,
   output logic                      send_done,
   output logic                      busy,
   best_arr_sender_if.master         bus
);

   state_e r_state;
   state_e w_next;
   pass_e  r_pass;
   logic   r_half;
   logic [2*DATA_WIDTH-1:0] r_hold;

   logic w_start;
   logic w_acc;
   logic w_adv;
   logic w_clr;
   logic w_last;
   logic [ADDR_WIDTH-1:0] w_addr;

   assign w_start = send_best_arr &&
                    (r_state == IDLE || r_state == DONE);
   assign w_acc   = (r_state == PUSH) && bus.out_fifo_wfull_n;
   assign w_adv   = w_acc && (r_pass == P_IDX || r_half);
   assign w_clr   = w_start;

   blocked_raster_counter u_cnt (
      .i_clk   (io_clk),
      .i_rst_n (io_rst_n),
      .i_clr   (w_clr),
      .i_adv   (w_adv),
      .o_addr  (w_addr),
      .o_last  (w_last)
   );

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         r_state <= IDLE;
         r_pass  <= P_IDX;
         r_half  <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_pass <= P_IDX;
            r_half <= 1'b0;
         end
         if (r_state == CAP) begin
            r_half <= 1'b0;
            r_hold <= (r_pass == P_DIST) ? bus.best_dist_rdata
                    : {{DATA_WIDTH{1'b0}}, bus.best_idx_rdata};
         end
         if (w_acc && r_pass == P_DIST && !r_half)
            r_half <= 1'b1;
         if (w_adv && w_last && r_pass == P_IDX)
            r_pass <= P_DIST;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, DONE: if (send_best_arr) w_next = RD;
         RD:         w_next = CAP;
         CAP:        w_next = PUSH;
         PUSH: begin
            if (w_adv) begin
               if (w_last && r_pass == P_DIST)
                  w_next = DONE;
               else
                  w_next = RD;
            end
         end
         default:    w_next = IDLE;
      endcase
   end

   // wdata is forced to zero outside PUSH so idle outputs stay quiet
   always_comb begin
      bus.mem_rd_en      = (r_state == RD);
      bus.mem_addr       = w_addr;
      bus.out_fifo_wenq  = (r_state == PUSH);
      bus.out_fifo_wdata = '0;
      if (r_state == PUSH) begin
         if (r_pass == P_DIST && r_half)
            bus.out_fifo_wdata = r_hold[2*DATA_WIDTH-1:DATA_WIDTH];
         else
            bus.out_fifo_wdata = r_hold[DATA_WIDTH-1:0];
      end
      send_done = (r_state == DONE);
      busy      = (r_state != IDLE) && (r_state != DONE);
   end

endmodule

// File: tb/tb_best_arr_sender.sv
// Directed bench for best_arr_sender: table vectors on the word stream
// plus backpressure, mid-stream start, reset abort and restart sequences.
module tb_best_arr_sender;
   import best_arr_sender_pkg::*;

   localparam int TOTAL = 3 * NUM_QUERYS;

   logic io_clk = 1'b0;
   logic io_rst_n = 1'b0;
   logic send_best_arr = 1'b0;
   logic send_done;
   logic busy;

   best_arr_sender_if bus ();

   best_arr_sender dut (
      .io_clk        (io_clk),
      .io_rst_n      (io_rst_n),
      .send_best_arr (send_best_arr),
      .send_done     (send_done),
      .busy          (busy),
      .bus           (bus.master)
   );

   always #5 io_clk = ~io_clk;

   int errors = 0;
   int checks = 0;

   // result buffers: idx[a]=a, dist[a]=a*4096+a, 1-cycle read latency
   always @(posedge io_clk) begin
      if (bus.mem_rd_en) begin
         bus.best_idx_rdata  <= 11'(bus.mem_addr);
         bus.best_dist_rdata <= 22'(bus.mem_addr) * 22'd4096
                              + 22'(bus.mem_addr);
      end
   end

   int bp_mode = 0;
   int bp_ph = 0;
   initial bus.out_fifo_wfull_n = 1'b1;
   always @(posedge io_clk) begin
      #1;
      if (bp_mode != 0) begin
         bp_ph = (bp_ph + 1) % 3;
         bus.out_fifo_wfull_n = (bp_ph != 0);
      end else begin
         bus.out_fifo_wfull_n = 1'b1;
      end
   end

   logic [10:0] got [0:2047];
   int   cnt = 0;
   logic pend = 1'b0;
   logic [10:0] pend_d = '0;
   int   stall_err = 0;

   always @(negedge io_clk) begin
      if (!io_rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            checks++;
            if (!(bus.out_fifo_wenq && bus.out_fifo_wdata == pend_d)) begin
               errors++;
               if (stall_err < 5)
                  $display("FAIL stall_hold: wenq=%0b wdata=%0d want 1/%0d",
                           bus.out_fifo_wenq, bus.out_fifo_wdata, pend_d);
               stall_err++;
            end
         end
         pend   = bus.out_fifo_wenq && !bus.out_fifo_wfull_n;
         pend_d = bus.out_fifo_wdata;
         if (bus.out_fifo_wenq && bus.out_fifo_wfull_n) begin
            if (cnt < 2048) got[cnt] = bus.out_fifo_wdata;
            cnt++;
         end
      end
   end

   function automatic int addr_of(input int p);
      int xi, y, x, px;
      xi = p % 4;
      y  = (p / 4) % 16;
      x  = (p / 64) % 4;
      px = p / 256;
      return px * 16 + y * 32 + x * 4 + xi;
   endfunction

   function automatic logic [10:0] exp_word(input int k);
      int a;
      logic [21:0] d;
      if (k < 512) return 11'(addr_of(k));
      a = addr_of((k - 512) / 2);
      d = 22'(a * 4096 + a);
      return ((k - 512) % 2 == 0) ? d[10:0] : d[21:11];
   endfunction

   typedef struct {
      int          k;
      logic [10:0] w;
   } vec_t;

   vec_t vt [16];

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic check_idle_outs(input string nm);
      check({nm, "_done"}, int'(send_done), 0);
      check({nm, "_busy"}, int'(busy), 0);
      check({nm, "_rden"}, int'(bus.mem_rd_en), 0);
      check({nm, "_wenq"}, int'(bus.out_fifo_wenq), 0);
      check({nm, "_wdata"}, int'(bus.out_fifo_wdata), 0);
      check({nm, "_addr"}, int'(bus.mem_addr), 0);
   endtask

   task automatic check_seq(input string nm);
      int bad = 0;
      int first = -1;
      for (int k = 0; k < TOTAL; k++) begin
         if (got[k] !== exp_word(k)) begin
            if (first < 0) first = k;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d bad words, first k=%0d got %0d want %0d",
                  nm, bad, first, got[first], exp_word(first));
      end
   endtask

   task automatic pulse_start();
      @(posedge io_clk);
      #1 send_best_arr = 1'b1;
      @(posedge io_clk);
      #1 send_best_arr = 1'b0;
   endtask

   task automatic run(input string nm, input bit mid, input bit from_done);
      int c;
      bit to;
      cnt = 0;
      pulse_start();
      if (from_done) check({nm, "_done_clr"}, int'(send_done), 0);
      check({nm, "_busy"}, int'(busy), 1);
      to = 1'b1;
      for (c = 0; c < 20000; c++) begin
         if (send_done) begin
            to = 1'b0;
            break;
         end
         if (mid && c == 1000) send_best_arr = 1'b1;
         if (mid && c == 1001) send_best_arr = 1'b0;
         @(posedge io_clk);
         #1;
      end
      send_best_arr = 1'b0;
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s_timeout: send_done=%0b want 1", nm, send_done);
      end
      @(negedge io_clk);
      check({nm, "_count"}, cnt, TOTAL);
      check({nm, "_busy_end"}, int'(busy), 0);
      check_seq({nm, "_seq"});
   endtask

   initial begin
      vt[0]  = '{0, 11'd0};
      vt[1]  = '{1, 11'd1};
      vt[2]  = '{2, 11'd2};
      vt[3]  = '{3, 11'd3};
      vt[4]  = '{4, 11'd32};
      vt[5]  = '{5, 11'd33};
      vt[6]  = '{6, 11'd34};
      vt[7]  = '{7, 11'd35};
      vt[8]  = '{64, 11'd4};
      vt[9]  = '{255, 11'd495};
      vt[10] = '{256, 11'd16};
      vt[11] = '{511, 11'd511};
      vt[12] = '{512, 11'd0};
      vt[13] = '{513, 11'd0};
      vt[14] = '{514, 11'd1};
      vt[15] = '{515, 11'd2};

      repeat (3) @(posedge io_clk);
      #1 check_idle_outs("reset");
      io_rst_n = 1'b1;
      repeat (2) @(posedge io_clk);
      #1 check_idle_outs("idle");

      run("free", 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         check($sformatf("vec_k%0d", vt[i].k), int'(got[vt[i].k]),
               int'(vt[i].w));
      check("last_hi", int'(got[TOTAL - 1]), 1022);

      bp_mode = 1;
      run("bp", 1'b0, 1'b1);
      bp_mode = 0;

      run("mid", 1'b1, 1'b1);

      cnt = 0;
      pulse_start();
      for (int c = 0; c < 20000 && cnt < 700; c++) @(posedge io_clk);
      #1 io_rst_n = 1'b0;
      #2 check_idle_outs("abort");
      repeat (2) @(posedge io_clk);
      #1 io_rst_n = 1'b1;
      @(negedge io_clk);
      check_idle_outs("post_rst");

      run("fresh", 1'b0, 1'b0);
      check("fresh_first", int'(got[0]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
